// File: rtl/tick_count_ctrl.sv
// Tick-divided up/down counter with an IDLE/RUN/PAUSE command FSM.
// Define TICK_COUNT_CTRL_STEP_EN to enable single-step advances in IDLE and PAUSE.
module tick_count_ctrl #(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned CNT_MAX = 9
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       STOP,
  input  logic       STEP,
  input  logic       DIR,
  output logic [3:0] COUNT,
  output logic       TICK,
  output logic       WRAP,
  output logic       RUNNING
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       CNT_TOP  = 4'(CNT_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;
  typedef enum logic [1:0] {CMD_NONE, CMD_STOP, CMD_START, CMD_STEP} cmd_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             run_q, run_d;

  cmd_e             cmd;
  logic             step_req;
  logic             advance;
  logic [3:0]       adv_cnt;
  logic             adv_wrap;

`ifdef TICK_COUNT_CTRL_STEP_EN
  assign step_req = STEP;
`else
  logic step_unused;
  assign step_unused = STEP;
  assign step_req    = 1'b0;
`endif

  // One command per cycle: STOP beats START beats STEP.
  always_comb begin
    cmd = CMD_NONE;
    if (STOP)          cmd = CMD_STOP;
    else if (START)    cmd = CMD_START;
    else if (step_req) cmd = CMD_STEP;
  end

  always_comb begin
    adv_cnt  = cnt_q;
    adv_wrap = 1'b0;
    if (DIR) begin
      if (cnt_q == CNT_TOP) begin
        adv_cnt  = 4'd0;
        adv_wrap = 1'b1;
      end else begin
        adv_cnt  = cnt_q + 4'd1;
      end
    end else begin
      if (cnt_q == 4'd0) begin
        adv_cnt  = CNT_TOP;
        adv_wrap = 1'b1;
      end else begin
        adv_cnt  = cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        case (cmd)
          CMD_START: begin
            state_d = RUN;
            div_d   = '0;
          end
          CMD_STEP: advance = 1'b1;
          default: ;
        endcase
      end
      RUN: begin
        // STOP on the terminal count leaves the divider at its last value,
        // so the tick fires on the first RUN cycle after resuming.
        if (cmd == CMD_STOP) begin
          state_d = PAUSE;
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          tick_d  = 1'b1;
          advance = 1'b1;
        end else begin
          div_d   = div_q + 1'b1;
        end
      end
      PAUSE: begin
        case (cmd)
          CMD_STOP: begin
            state_d = IDLE;
            div_d   = '0;
            cnt_d   = 4'd0;
          end
          CMD_START: state_d = RUN;
          CMD_STEP:  advance = 1'b1;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
    if (advance) begin
      cnt_d  = adv_cnt;
      wrap_d = adv_wrap;
    end
  end

  assign run_d = (state_d == RUN);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= 4'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      run_q   <= run_d;
    end
  end

  assign COUNT   = cnt_q;
  assign TICK    = tick_q;
  assign WRAP    = wrap_q;
  assign RUNNING = run_q;

endmodule

// File: doc/tick_count_ctrl.md
TICK_COUNT_CTRL -- requirements
Module: tick_count_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000000: clock cycles per tick; legal range 2 to 2^26.
REQ-002 SHALL have parameter CNT_MAX, default 9: highest COUNT value; legal range 1 to 15.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port START, input, 1 bit: level-sampled request to run.
REQ-006 SHALL have port STOP, input, 1 bit: level-sampled request to pause or clear.
REQ-007 SHALL have port STEP, input, 1 bit: level-sampled request for a single manual advance.
REQ-008 SHALL have port DIR, input, 1 bit: 1 counts up, 0 counts down; sampled at each advance.
REQ-009 SHALL have port COUNT, output, 4 bits, registered: current count.
REQ-010 SHALL have port TICK, output, 1 bit, registered: one-cycle pulse on each automatic advance.
REQ-011 SHALL have port WRAP, output, 1 bit, registered: one-cycle pulse on any advance that wraps.
REQ-012 SHALL have port RUNNING, output, 1 bit, registered: high while in RUN.

Function
REQ-013 SHALL implement states IDLE, RUN and PAUSE.
REQ-014 SHALL apply one command per cycle with priority STOP > START > STEP; lower-priority inputs are ignored that cycle.
REQ-015 SHALL apply these transitions:
- IDLE+START -> RUN
- RUN+STOP -> PAUSE
- PAUSE+START -> RUN
- PAUSE+STOP -> IDLE
- IDLE+STOP -> IDLE
- START in RUN: no effect
REQ-016 SHALL, on PAUSE->IDLE, clear COUNT and the divider to 0 on the same edge.
REQ-017 SHALL clear the internal divider (width ceil(log2(CLK_DIV))) to 0 on IDLE->RUN; on PAUSE->RUN it SHALL resume from its held value.
REQ-018 SHALL, in RUN, increment the divider each cycle; at CLK_DIV-1 the next edge SHALL reset it to 0, pulse TICK and advance COUNT together.
REQ-019 SHALL assert the first TICK exactly CLK_DIV rising edges after the edge that entered RUN from IDLE.
REQ-020 SHALL hold the divider and deassert TICK in IDLE and PAUSE.
REQ-021 SHALL advance COUNT as follows:
- up: +1, with CNT_MAX -> 0 wrap
- down: -1, with 0 -> CNT_MAX wrap
- WRAP pulses on the same edge as any wrapping advance
REQ-022 SHALL treat STOP and a terminal divider value in the same cycle as STOP winning: no TICK, divider held at CLK_DIV-1, so the first cycle after resuming produces the TICK.
REQ-023 SHALL, for STEP in IDLE or PAUSE, perform exactly one advance on the next edge:
- TICK stays low
- WRAP follows REQ-021
- state unchanged
- STEP held high advances once per cycle
REQ-024 SHALL ignore STEP in RUN.
REQ-025 SHALL drive RUNNING high in the same cycle the state register holds RUN.

Reset
REQ-026 SHALL, while RST_N is low, immediately force state IDLE, COUNT=0, TICK=0, WRAP=0, RUNNING=0 and divider=0, regardless of CLK.
REQ-027 SHALL resume operation on the first rising edge after RST_N deasserts; reset mid-RUN loses all progress.

Configuration
REQ-028 SHALL, with macro TICK_COUNT_CTRL_STEP_EN defined, implement STEP per REQ-023/REQ-024.
REQ-029 SHALL, without TICK_COUNT_CTRL_STEP_EN, keep the STEP port but ignore it entirely; COUNT changes only via RUN ticks, PAUSE->IDLE clear or reset.

Verification (CLK_DIV=4, CNT_MAX=9, macro defined unless noted)
REQ-030 SHALL cover: reset, START pulse, DIR=1 -> TICK on edges 4, 8, 12 after entering RUN; COUNT 1, 2, 3; RUNNING=1.
REQ-031 SHALL cover: run 10 ticks up -> 10th tick gives COUNT 9->0 with WRAP and TICK both high for one cycle.
REQ-032 SHALL cover: STOP at divider=2, wait 20 cycles, START -> no TICK while paused; next TICK 2 edges after resume.
REQ-033 SHALL cover: in PAUSE, DIR=0, COUNT=0, STEP one cycle -> COUNT=9, WRAP=1, TICK=0; STOP -> IDLE with COUNT=0.
REQ-034 SHALL cover: START, STOP and STEP high together in RUN -> PAUSE; COUNT unchanged.
REQ-035 SHALL cover: RST_N low mid-RUN between edges -> outputs 0 before the next edge; macro undefined, STEP in IDLE -> COUNT stays 0.
